// File: rtl/coeff_loader.sv
// -----------------------------------------------------------------------------
// coeff_loader
//
// Write-side sequencer for the coefficient register interface. A single start
// pulse captures a packed set of NUM_COEFF coefficients into a shadow register.
// The block then issues one load per coefficient, starting at select 0 and
// counting upward. A downstream hold stalls the sequence so that coefficients
// never change while a sample is in flight. The outputs connect port-for-port
// to coeff_reg.
//
// Parameters:
//   NUM_COEFF   - coefficient slots per sequence (1..4, limited by 2-bit select)
//   COEFF_WIDTH - width of each packed coefficient, zero-extended to 16 bits
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   start      in   request a new load sequence (only looked at while idle)
//   coeff_data in   packed coefficients, slot k at [k*COEFF_WIDTH +: COEFF_WIDTH]
//   hold       in   downstream busy, suppresses loads while high
//   coeff_ld   out  load strobe to coeff_reg
//   coeff_sel  out  slot address to coeff_reg
//   coeff_in   out  zero-extended coefficient value for the addressed slot
//   busy       out  sequence in progress
//   done       out  one-cycle pulse after the final load
// -----------------------------------------------------------------------------
module coeff_loader #(
   parameter int NUM_COEFF   = 3,
   parameter int COEFF_WIDTH = 12
) (
   input  logic                             clk,
   input  logic                             n_rst,
   input  logic                             start,
   input  logic [NUM_COEFF*COEFF_WIDTH-1:0] coeff_data,
   input  logic                             hold,
   output logic                             coeff_ld,
   output logic [1:0]                       coeff_sel,
   output logic [15:0]                      coeff_in,
   output logic                             busy,
   output logic                             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] LAST_INDEX = 2'(NUM_COEFF - 1);

   state_t                           state_q, state_d;
   logic [1:0]                       index_q, index_d;
   logic [NUM_COEFF*COEFF_WIDTH-1:0] shadow_q, shadow_d;
   logic [COEFF_WIDTH-1:0]           pendingSlot;

   // The slot being presented comes from the shadow copy. The host can
   // therefore change coeff_data freely once a sequence has been accepted.
   assign pendingSlot = shadow_q[32'(index_q)*COEFF_WIDTH +: COEFF_WIDTH];

   // State, slot index and captured coefficient set
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         index_q  <= 2'd0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         shadow_q <= shadow_d;
      end
   end

   // Next-state and output decode. Outputs depend only on state, index and
   // hold. As a result, a stalled slot stays on coeff_sel/coeff_in with the
   // strobe dropped until hold clears.
   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      shadow_d  = shadow_q;
      coeff_ld  = 1'b0;
      coeff_sel = 2'd0;
      coeff_in  = 16'd0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               shadow_d = coeff_data;
               index_d  = 2'd0;
               state_d  = LOAD;
            end
         end

         LOAD: begin
            busy      = 1'b1;
            coeff_ld  = !hold;
            coeff_sel = index_q;
            coeff_in  = 16'(pendingSlot);
            if (!hold) begin
               if (index_q == LAST_INDEX) begin
                  state_d = DONE;
               end else begin
                  index_d = index_q + 2'd1;
               end
            end
         end

         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            index_d = 2'd0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            index_d = 2'd0;
         end
      endcase
   end

endmodule
